// File: rtl/waveform_generator_if.sv
// Stream and register-bank bundle for the waveform generator.
// M_AXIS_tlast exists only when WG_TLAST_EN is defined.
interface waveform_generator_if #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32
);
    logic [1:0]                  WG_mode;
    logic [AXIS_TDATA_WIDTH-2:0] WG_amplitude;
    logic [AXIS_TDATA_WIDTH-2:0] WG_step;
    logic [4:0]                  WG_log_rate;
    logic [4:0]                  WG_log_half;
    logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata;
    logic                        M_AXIS_tvalid;
    logic                        M_AXIS_tready;
`ifdef WG_TLAST_EN
    logic                        M_AXIS_tlast;

    modport master (
        input  WG_mode, WG_amplitude, WG_step, WG_log_rate, WG_log_half, M_AXIS_tready,
        output M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast
    );
    modport slave (
        output WG_mode, WG_amplitude, WG_step, WG_log_rate, WG_log_half, M_AXIS_tready,
        input  M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast
    );
`else
    modport master (
        input  WG_mode, WG_amplitude, WG_step, WG_log_rate, WG_log_half, M_AXIS_tready,
        output M_AXIS_tdata, M_AXIS_tvalid
    );
    modport slave (
        output WG_mode, WG_amplitude, WG_step, WG_log_rate, WG_log_half, M_AXIS_tready,
        input  M_AXIS_tdata, M_AXIS_tvalid
    );
`endif
endinterface

// File: rtl/waveform_generator.sv
// AXI4-Stream master producing triangle / sawtooth / square test waveforms.
// Optional macro WG_TLAST_EN adds an end-of-period M_AXIS_tlast.
module waveform_generator #(
    parameter int unsigned AXIS_TDATA_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    waveform_generator_if.master m_axis
);
    localparam int unsigned W     = AXIS_TDATA_WIDTH;
    localparam int unsigned XW    = AXIS_TDATA_WIDTH + 1;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {MODE_OFF, MODE_TRI, MODE_SAW, MODE_SQR} mode_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    mode_e                 r_mode;
    dir_e                  r_dir;
    logic                  r_first;
    logic [CNT_W-1:0]      r_rate_cnt;
    logic [CNT_W-1:0]      r_half_cnt;
    logic signed [W-1:0]   r_v;
    logic [W-1:0]          r_tdata;
    logic                  r_tvalid;

    mode_e                 w_mode_in;
    logic                  w_mode_chg;
    logic [CNT_W-1:0]      w_rate_term;
    logic [CNT_W-1:0]      w_half_term;
    logic                  w_tick;
    logic                  w_free;
    logic                  w_gen;
    logic                  w_zero;
    logic signed [XW-1:0]  w_amp;
    logic signed [XW-1:0]  w_step;
    logic signed [XW-1:0]  w_v_x;
    logic signed [XW-1:0]  w_v_c;
    logic signed [XW-1:0]  w_up;
    logic signed [XW-1:0]  w_dn;
    logic signed [XW-1:0]  w_sample;
    dir_e                  w_dir_nxt;
    logic [CNT_W-1:0]      w_half_nxt;

    assign w_mode_in   = mode_e'(m_axis.WG_mode);
    assign w_mode_chg  = (w_mode_in != r_mode);
    assign w_rate_term = ~({CNT_W{1'b1}} << m_axis.WG_log_rate);
    assign w_half_term = ~({CNT_W{1'b1}} << m_axis.WG_log_half);
    // >= so that shrinking the rate mid-run never strands the counter past terminal
    assign w_tick      = (r_rate_cnt >= w_rate_term);
    assign w_free      = !r_tvalid || m_axis.M_AXIS_tready;
    assign w_gen       = w_tick && w_free && !w_mode_chg && (r_mode != MODE_OFF);
    assign w_zero      = (m_axis.WG_amplitude == '0) || (m_axis.WG_step == '0);

    // Datapath at W+1 bits so v +/- S can never overflow
    assign w_amp  = $signed(XW'(m_axis.WG_amplitude));
    assign w_step = $signed(XW'(m_axis.WG_step));
    assign w_v_x  = XW'(r_v);
    assign w_v_c  = (w_v_x > w_amp) ? w_amp : ((w_v_x < -w_amp) ? -w_amp : w_v_x);
    assign w_up   = w_v_c + w_step;
    assign w_dn   = w_v_c - w_step;

    // Next sample and generator state for the active mode
    always_comb begin
        w_sample   = '0;
        w_dir_nxt  = r_dir;
        w_half_nxt = r_half_cnt;
        case (r_mode)
            MODE_TRI: begin
                if (w_zero || r_first) begin
                    w_sample = '0;
                end else if (r_dir == DIR_UP) begin
                    if (w_up >= w_amp) begin
                        w_sample  = w_amp;
                        w_dir_nxt = DIR_DOWN;
                    end else begin
                        w_sample = w_up;
                    end
                end else begin
                    if (w_dn <= -w_amp) begin
                        w_sample  = -w_amp;
                        w_dir_nxt = DIR_UP;
                    end else begin
                        w_sample = w_dn;
                    end
                end
            end
            MODE_SAW: begin
                if (w_zero || r_first)   w_sample = '0;
                else if (w_up > w_amp)   w_sample = -w_amp;
                else                     w_sample = w_up;
            end
            MODE_SQR: begin
                w_sample = (r_dir == DIR_DOWN) ? -w_amp : w_amp;
                if (r_half_cnt >= w_half_term) begin
                    w_half_nxt = '0;
                    w_dir_nxt  = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
                end else begin
                    w_half_nxt = r_half_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_mode     <= MODE_OFF;
            r_dir      <= DIR_UP;
            r_first    <= 1'b1;
            r_rate_cnt <= '0;
            r_half_cnt <= '0;
            r_v        <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
        end else begin
            r_mode <= w_mode_in;
            if (w_mode_chg) begin
                r_dir      <= DIR_UP;
                r_first    <= 1'b1;
                r_rate_cnt <= '0;
                r_half_cnt <= '0;
                r_v        <= '0;
            end else begin
                // Counter parks on terminal count while the slot is busy
                if (!w_tick)     r_rate_cnt <= r_rate_cnt + CNT_W'(1);
                else if (w_free) r_rate_cnt <= '0;
                if (w_gen) begin
                    r_v        <= W'(w_sample);
                    r_dir      <= w_dir_nxt;
                    r_half_cnt <= w_half_nxt;
                    r_first    <= 1'b0;
                end
            end
            if (w_gen) begin
                r_tdata  <= W'(w_sample);
                r_tvalid <= 1'b1;
            end else if (w_free) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis.M_AXIS_tdata  = r_tdata;
    assign m_axis.M_AXIS_tvalid = r_tvalid;

`ifdef WG_TLAST_EN
    logic r_tlast;
    logic w_last;

    // End-of-period marker for the sample being generated this cycle
    always_comb begin
        w_last = 1'b0;
        case (r_mode)
            MODE_TRI: w_last = !w_zero && !r_first && (r_dir == DIR_DOWN) && (w_dn <= -w_amp);
            MODE_SAW: w_last = !w_zero && ((w_sample + w_step) > w_amp);
            MODE_SQR: w_last = (r_dir == DIR_DOWN) && (r_half_cnt >= w_half_term);
            default:  w_last = 1'b0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn)   r_tlast <= 1'b0;
        else if (w_gen) r_tlast <= w_last;
    end

    assign m_axis.M_AXIS_tlast = r_tlast;
`endif
endmodule
